fetch_unit: RTL

//  Parametrised instruction-fetch stage for the pipelined core: PC register, PC+4 sequencer,

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES   = 4;
   localparam int unsigned PC_ALIGN_BITS = 2;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

   typedef logic [31:0] perf_cnt_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO decoupling instruction fetch from decode. DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign count = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Push into a full queue is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Next-state pointers and occupancy; flush discards everything.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, sequential/redirect PC selection and a fetch queue
// feeding decode. Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN        = 32,
   parameter logic [XLEN-1:0]  RESET_PC    = '0,
   parameter int unsigned      QUEUE_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            redirect_valid,
   input  logic [XLEN-1:0]                 redirect_pc,
   output logic [XLEN-1:0]                 imem_addr,
   input  logic [XLEN-1:0]                 imem_rdata,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [XLEN-1:0]                 out_pc,
   output logic [XLEN-1:0]                 out_pc_plus4,
   output logic [XLEN-1:0]                 out_instr,
   output logic [$clog2(QUEUE_DEPTH):0]    queue_count
`ifdef FETCH_PERF_CNT_EN
   ,
   output perf_cnt_t                       fetch_cnt,
   output perf_cnt_t                       stall_cnt
`endif
);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [2*XLEN-1:0] head_data;
   logic              q_empty, q_full;
   logic              deq, can_enq, enq;
   logic              unused_align_bits;

   // Low address bits of a redirect target are discarded.
   assign unused_align_bits = ^redirect_pc[PC_ALIGN_BITS-1:0];

   assign imem_addr = pc_q;
   assign out_valid = ~q_empty;
   assign deq       = out_valid & out_ready;
   assign can_enq   = ~q_full | deq;
   assign enq       = ~redirect_valid & can_enq;

   // Redirect wins over sequential fetch; with no room the PC holds.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
      end else if (can_enq) begin
         pc_d = pc_q + XLEN'(INSTR_BYTES);
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   fetch_queue #(
      .WIDTH (2 * XLEN),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (enq),
      .push_data ({pc_q, imem_rdata}),
      .pop       (deq),
      .head_data (head_data),
      .count     (queue_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   // Decode-facing outputs read as zero while the queue is empty.
   always_comb begin
      out_pc       = '0;
      out_pc_plus4 = '0;
      out_instr    = XLEN'(NOP_INSTR);
      if (out_valid) begin
         out_pc       = head_data[2*XLEN-1:XLEN];
         out_pc_plus4 = head_data[2*XLEN-1:XLEN] + XLEN'(INSTR_BYTES);
         out_instr    = head_data[XLEN-1:0];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   perf_cnt_t fetch_cnt_q, stall_cnt_q;

   // Count enqueues and cycles lost to a full queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (enq)                         fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (!can_enq && !redirect_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
